bus_arb_mux: RTL and testbench
==============================

# bus_arb_mux

Parametrised, registered datapath bus multiplexer. Each cycle it samples N source words and an N-bit drive-request vector, resolves the requests by fixed priority (lowest index wins), and drives the winning word onto a registered bus after PIPE cycles. It flags multi-driver contention with a sticky flag and a saturating counter, and supports hold-or-zero behaviour on idle cycles. It sits between the register file/special registers (R0–R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN) and every bus consumer in the datapath.

## Interface
- W, 32, data width of each source and of the bus
- N, 24, number of sources (2..32)
- PIPE, 1, output latency in cycles (1 or 2)
- HOLD, 1, idle behaviour: 1 = bus_out holds last value, 0 = bus_out forced to 0
- CNTW, 8, width of the contention counter

- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- src_data  in  N*W  source i occupies bits [i*W +: W]
- src_sel  in  N  drive request per source; one-hot expected
- err_clr  in  1  synchronous clear of err_multi and err_count
- bus_out  out  W  registered bus value
- bus_valid  out  1  bus_out carries a granted source this cycle
- bus_src  out  SELW  index of the granted source; SELW = max(1, clog2(N))
- err_multi  out  1  sticky: at least one multi-hot src_sel sampled since the last clear
- err_count  out  CNTW  number of multi-hot cycles, saturating

## Operation
- Resolution (combinational, cycle t): any = |src_sel; grant = lowest set index; multi = more than one bit set.
- Data path: whenever any=1, the selected word is src_data[grant]. The stage samples data every cycle, not only when src_sel changes. A data change on an unchanged selection propagates.
- Stage 1 captures {word, any, grant}. With PIPE=2, stage 2 copies stage 1 unconditionally. The outputs are the last stage.
- Idle (any=0): bus_valid=0 and bus_src holds its previous value. bus_out holds its previous value if HOLD=1 and becomes 0 if HOLD=0.
- Contention: in a multi cycle, data is still delivered from the lowest index and bus_valid=1. err_multi is set to 1. err_count increments, saturating at 2^CNTW-1.
- err_clr: err_multi returns to 0 and err_count returns to 0. If err_clr and multi occur in the same cycle, the new event wins: err_multi=1, err_count=1.
- No FSM. State consists of the pipeline registers, the sticky flag and the counter.

## Timing
- Reset: asserting reset_n low immediately forces every output and every pipeline register to 0 (bus_out=0, bus_valid=0, bus_src=0, err_multi=0, err_count=0), including mid-stream. Stages in flight are discarded.
- After deassertion, the first rising edge samples normally.
- Latency: inputs sampled at edge k appear on bus_out/bus_valid/bus_src after edge k+PIPE-1, so they are visible in cycle k+PIPE-1..k+PIPE.
- Throughput: one transfer per cycle, back-to-back, with order preserved.
- err_multi and err_count always update at the edge that samples the offending src_sel, independent of PIPE. With PIPE=2 the flag leads the corresponding bus_out by one cycle.
- Counter at saturation with another multi: it stays at 2^CNTW-1.
- N not a power of two: src_sel bits at N and above do not exist. The grant never exceeds N-1.

## Structure
- Shared package bus_pkg holds:
  - source index constants: R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23, with N_SRC=24;
  - the SELW derivation function.
- One sub-module, bus_prio_enc: combinational N-to-SELW priority encoder with any and multi outputs. The top level holds the word select, the pipeline, and the error logic.

## Test plan
All scenarios use the defaults unless stated otherwise.
- Single driver: src_sel=1<<20 (PC) with PC word 0x0000_0100 -> one edge later bus_out=0x0000_0100, bus_valid=1, bus_src=20, err_multi=0.
- Data tracking: src_sel held at 1<<5, R5 changes 0xA→0xB → bus_out becomes 0xB one edge after the change.
- Contention: src_sel=(1<<3)|(1<<21), R3=0x1234 -> bus_out=0x1234, bus_src=3, bus_valid=1, err_multi=1, err_count=1. Then err_clr alone -> err_multi=0, err_count=0.
- Idle: after bus_out=0x55, src_sel=0 -> bus_valid=0, bus_out=0x55 (HOLD=1); rerun with HOLD=0 -> bus_out=0.
- Saturation, CNTW=2: five consecutive multi-hot cycles -> err_count=3. Then err_clr plus a multi in the same cycle -> err_count=1, err_multi=1.
- PIPE=2 with reset: sources 0,1,2 selected on consecutive edges -> bus_src sequence 0,1,2, starting two edges later. Asserting reset_n=0 mid-sequence -> all outputs 0 immediately, and no stale value emerges after release.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus source indices and select-width helper
package bus_pkg;

    localparam int R0     = 0;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int CSIGN  = 23;
    localparam int N_SRC  = 24;

    // Index width for n sources, never below one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// rtl/bus_prio_enc.sv - lowest-index-wins priority encoder with any/multi flags
module bus_prio_enc #(
    parameter int N    = 24,
    parameter int SELW = 5
) (
    input  logic [N-1:0]    sel,
    output logic [SELW-1:0] grant,
    output logic            any,
    output logic            multi
);

    localparam logic [N-1:0] ONE = N'(1);

    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                grant = SELW'(i);
            end
        end
    end

    assign any   = |sel;
    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi = |(sel & (sel - ONE));

endmodule

// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - registered priority bus multiplexer with contention tracking
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int  W    = 32,
    parameter int  N    = N_SRC,
    parameter int  PIPE = 1,
    parameter bit  HOLD = 1'b1,
    parameter int  CNTW = 8,
    localparam int SELW = sel_w(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N*W-1:0]   src_data,
    input  logic [N-1:0]     src_sel,
    input  logic             err_clr,
    output logic [W-1:0]     bus_out,
    output logic             bus_valid,
    output logic [SELW-1:0]  bus_src,
    output logic             err_multi,
    output logic [CNTW-1:0]  err_count
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [SELW-1:0] grant;
    logic            any;
    logic            multi;
    logic [W-1:0]    sel_word;

    logic [W-1:0]    s1_word_q, s1_word_d;
    logic            s1_valid_q, s1_valid_d;
    logic [SELW-1:0] s1_src_q, s1_src_d;
    logic            err_multi_q, err_multi_d;
    logic [CNTW-1:0] err_count_q, err_count_d;

    bus_prio_enc #(.N(N), .SELW(SELW)) u_enc (
        .sel   (src_sel),
        .grant (grant),
        .any   (any),
        .multi (multi)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                sel_word = src_data[i*W +: W];
            end
        end
    end

    // Idle cycles keep the last source index; the word holds or drops to zero.
    always_comb begin
        s1_word_d  = HOLD ? s1_word_q : '0;
        s1_src_d   = s1_src_q;
        s1_valid_d = any;
        if (any) begin
            s1_word_d = sel_word;
            s1_src_d  = grant;
        end
    end

    // A fresh contention event outranks a clear landing on the same edge.
    always_comb begin
        err_multi_d = err_multi_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_multi_d = 1'b0;
            err_count_d = '0;
        end
        if (multi) begin
            err_multi_d = 1'b1;
            if (err_clr) begin
                err_count_d = CNTW'(1);
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_word_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_src_q    <= '0;
            err_multi_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_word_q   <= s1_word_d;
            s1_valid_q  <= s1_valid_d;
            s1_src_q    <= s1_src_d;
            err_multi_q <= err_multi_d;
            err_count_q <= err_count_d;
        end
    end

    generate
        if (PIPE == 2) begin : g_pipe2
            logic [W-1:0]    s2_word_q, s2_word_d;
            logic            s2_valid_q, s2_valid_d;
            logic [SELW-1:0] s2_src_q, s2_src_d;

            always_comb begin
                s2_word_d  = s1_word_q;
                s2_valid_d = s1_valid_q;
                s2_src_d   = s1_src_q;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s2_word_q  <= '0;
                    s2_valid_q <= 1'b0;
                    s2_src_q   <= '0;
                end else begin
                    s2_word_q  <= s2_word_d;
                    s2_valid_q <= s2_valid_d;
                    s2_src_q   <= s2_src_d;
                end
            end

            assign bus_out   = s2_word_q;
            assign bus_valid = s2_valid_q;
            assign bus_src   = s2_src_q;
        end else begin : g_pipe1
            assign bus_out   = s1_word_q;
            assign bus_valid = s1_valid_q;
            assign bus_src   = s1_src_q;
        end
    endgenerate

    assign err_multi = err_multi_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - self-checking bench: PIPE=1/HOLD=1/CNTW=8 and PIPE=2/HOLD=0/CNTW=2 side by side
module tb_bus_arb_mux;
    import bus_pkg::*;

    localparam int W = 32;
    localparam int N = N_SRC;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_sel;
    logic           err_clr;

    logic [W-1:0] out_a, out_b;
    logic         valid_a, valid_b;
    logic [4:0]   bsrc_a, bsrc_b;
    logic         em_a, em_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    int vectors = 0;
    int miscompares = 0;

    bus_arb_mux #(.W(W), .N(N), .PIPE(1), .HOLD(1'b1), .CNTW(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
        .err_clr(err_clr), .bus_out(out_a), .bus_valid(valid_a), .bus_src(bsrc_a),
        .err_multi(em_a), .err_count(cnt_a)
    );

    bus_arb_mux #(.W(W), .N(N), .PIPE(2), .HOLD(1'b0), .CNTW(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
        .err_clr(err_clr), .bus_out(out_b), .bus_valid(valid_b), .bus_src(bsrc_b),
        .err_multi(em_b), .err_count(cnt_b)
    );

    always #5 clock = ~clock;

    // Reference state: A is what a one-stage bus shows, B keeps a stage in flight.
    logic [31:0] ma_word, mb1_word, mb_word;
    bit          ma_valid, mb1_valid, mb_valid;
    int          ma_src, mb1_src, mb_src;
    bit          ma_err, mb_err;
    int          ma_cnt, mb_cnt;

    task automatic model_reset();
        ma_word = 0; ma_valid = 0; ma_src = 0; ma_err = 0; ma_cnt = 0;
        mb1_word = 0; mb1_valid = 0; mb1_src = 0;
        mb_word = 0; mb_valid = 0; mb_src = 0; mb_err = 0; mb_cnt = 0;
    endtask

    task automatic model_edge();
        bit any;
        bit multi;
        int g;
        logic [31:0] w;
        any   = (src_sel != 0);
        multi = ($countones(src_sel) > 1);
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (src_sel[i] && g < 0) g = i;
        end
        w = any ? src_data[g*W +: W] : 32'h0;

        if (any) begin
            ma_word = w;
            ma_src  = g;
        end
        ma_valid = any;

        mb_word  = mb1_word;
        mb_valid = mb1_valid;
        mb_src   = mb1_src;
        mb1_word  = w;
        mb1_valid = any;
        if (any) mb1_src = g;

        if (err_clr) begin
            ma_err = 0; ma_cnt = 0; mb_err = 0; mb_cnt = 0;
        end
        if (multi) begin
            ma_err = 1;
            mb_err = 1;
            ma_cnt = (ma_cnt + 1 > 255) ? 255 : ma_cnt + 1;
            mb_cnt = (mb_cnt + 1 > 3) ? 3 : mb_cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.bus_out",   out_a,   ma_word);
        chk("a.bus_valid", {31'b0, valid_a}, {31'b0, ma_valid});
        chk("a.bus_src",   {27'b0, bsrc_a},  ma_src);
        chk("a.err_multi", {31'b0, em_a},    {31'b0, ma_err});
        chk("a.err_count", {24'b0, cnt_a},   ma_cnt);
        chk("b.bus_out",   out_b,   mb_word);
        chk("b.bus_valid", {31'b0, valid_b}, {31'b0, mb_valid});
        chk("b.bus_src",   {27'b0, bsrc_b},  mb_src);
        chk("b.err_multi", {31'b0, em_b},    {31'b0, mb_err});
        chk("b.err_count", {30'b0, cnt_b},   mb_cnt);
    endtask

    task automatic cycle(input logic [N-1:0] sel, input logic clr);
        src_sel = sel;
        err_clr = clr;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        src_data[idx*W +: W] = val;
    endtask

    // Reset is asserted between edges and must clear outputs without a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] sel;
        int r;
        reset_n  = 1'b0;
        src_data = '0;
        src_sel  = '0;
        err_clr  = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        set_word(PC, 32'h0000_0100);
        cycle(N'(1) << PC, 1'b0);
        chk("single.word", out_a, 32'h0000_0100);
        chk("single.src", {27'b0, bsrc_a}, 32'd20);
        chk("single.valid", {31'b0, valid_a}, 32'd1);

        set_word(5, 32'hA);
        cycle(N'(1) << 5, 1'b0);
        set_word(5, 32'hB);
        cycle(N'(1) << 5, 1'b0);
        chk("track.word", out_a, 32'hB);

        set_word(3, 32'h1234);
        cycle((N'(1) << 3) | (N'(1) << MDR), 1'b0);
        chk("contend.word", out_a, 32'h1234);
        chk("contend.src", {27'b0, bsrc_a}, 32'd3);
        chk("contend.count", {24'b0, cnt_a}, 32'd1);
        cycle('0, 1'b1);
        chk("clear.flag", {31'b0, em_a}, 32'd0);

        set_word(7, 32'h55);
        cycle(N'(1) << 7, 1'b0);
        cycle('0, 1'b0);
        chk("idle.hold", out_a, 32'h55);
        cycle('0, 1'b0);
        chk("idle.zero", out_b, 32'h0);

        for (int i = 0; i < 5; i++) cycle(N'(3) << i, 1'b0);
        chk("sat.count", {30'b0, cnt_b}, 32'd3);
        cycle(N'(6), 1'b1);
        chk("sat.clr_multi", {30'b0, cnt_b}, 32'd1);

        cycle(N'(1), 1'b0);
        cycle(N'(2), 1'b0);
        chk("pipe2.src0", {27'b0, bsrc_b}, 32'd0);
        cycle(N'(4), 1'b0);
        chk("pipe2.src1", {27'b0, bsrc_b}, 32'd1);
        cycle(N'(1) << 9, 1'b0);
        chk("pipe2.src2", {27'b0, bsrc_b}, 32'd2);
        set_word(10, 32'hDEAD_BEEF);
        cycle(N'(1) << 10, 1'b0);
        #3;
        do_reset();
        cycle('0, 1'b0);
        chk("reset.nostale", out_b, 32'h0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) set_word(i, $urandom);
            r = $urandom_range(0, 9);
            if (r < 2) sel = '0;
            else if (r < 7) sel = N'(1) << $urandom_range(0, N - 1);
            else sel = N'($urandom);
            cycle(sel, ($urandom_range(0, 7) == 0));
            if (n == 200) begin
                #2;
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
